stream_checker: RTL and testbench
=================================

Name: stream_checker

Overview:
- Synthesisable, parametrised successor to the simulation-only word checks used around main_core_serialCmd.
- Expected words are queued in an internal FIFO.
- DUT output words are drained through the codebase's isReady/canReceive handshake and compared under a mask.
- Mismatches, unexpected outputs and the first failure are recorded for on-chip self-test of FrodoKEM datapath streams.

Parameters:
- W, 64: data word width in bits.
- DEPTH, 16: expected-FIFO depth in words; power of two, at least 2.
- CNT_W, 16: width of the word and error counters.
- STOP_ON_FAIL, 0: if 1, stop draining the DUT after the first failure.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- clr  in  1  synchronous clear of FIFO, counters and flags
- exp  in  W  expected word
- exp_isReady  in  1  exp is valid
- exp_canReceive  out  1  FIFO not full
- mask  in  W  per-bit compare enable, sampled with exp and stored alongside it
- dut  in  W  DUT output word
- dut_isReady  in  1  DUT word is valid
- dut_canReceive  out  1  checker will consume a DUT word this cycle
- strict  in  1  flag DUT output offered while the FIFO is empty
- fail  out  1  sticky failure flag
- halted  out  1  STOP_ON_FAIL stop is active
- wordCount  out  CNT_W  number of compared words
- errCount  out  CNT_W  number of mismatches plus unexpected words
- firstErr_idx  out  CNT_W  wordCount value at the first failure
- firstErr_got  out  W  DUT word at the first failure
- firstErr_exp  out  W  masked expected word at the first failure
- empty  out  1  FIFO empty

Behaviour:
- Reset (rst_n low, asynchronous): FIFO empty, all counters 0, fail=0, halted=0, firstErr_* = 0, exp_canReceive=1, dut_canReceive=0, empty=1.
- clr: same effect as reset, applied synchronously; clr takes priority over every other event in that cycle.
- Push: when exp_isReady && exp_canReceive, {exp, mask} is written at the write pointer. exp_canReceive = count < DEPTH.
- Pop/compare: dut_canReceive = !empty && !halted, combinational from registered state only. It must not depend on dut_isReady, so there is no combinational loop.
- A compare happens on a cycle where dut_isReady && dut_canReceive. In that cycle:
  - Mismatch when ((dut ^ exp_head) & mask_head) != 0.
  - wordCount increments, saturating at 2^CNT_W-1.
  - The FIFO entry is popped.
- Mismatch effects: errCount increments (saturating) and fail is set. If fail was 0 before this cycle, firstErr_idx, firstErr_got and firstErr_exp (= exp_head & mask_head) are captured from the pre-increment wordCount.
- Unexpected output: a cycle with strict && dut_isReady && empty && !halted.
  - errCount increments and fail is set.
  - First capture is the same as for a mismatch, with firstErr_exp = 0.
  - No word is consumed (dut_canReceive stays 0).
  - The event counts every cycle it persists.
- STOP_ON_FAIL=1: halted is set on the cycle after the first failure and stays set until clr or reset. While halted:
  - dut_canReceive=0.
  - Pushes are still accepted until the FIFO is full.
- STOP_ON_FAIL=0: halted is tied to 0.
- Simultaneous push and pop: legal at any count, including full (the pop frees a slot in the same cycle, but exp_canReceive is computed from the registered count, so no push is accepted when full) and empty (no pop happens because dut_canReceive=0).
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits. empty = (count == 0).
- Latency: compare result and counters update on the consuming edge and are visible the next cycle. A word pushed at edge N can be compared at edge N+1.
- rst_n asserted mid-stream discards all FIFO contents and results. No partial state survives.

Test Plan:
- Reset, push 4 words 0x0..01 through 0x0..04 with mask all-ones, DUT returns the same 4 words with dut_isReady held -> 4 consumptions on 4 consecutive edges, wordCount=4, errCount=0, fail=0, empty=1.
- Push 3 words, DUT returns the 2nd word as 0xDEAD...BEEF -> fail=1, errCount=1, firstErr_idx=1, firstErr_got=0xDEAD...BEEF, firstErr_exp = 2nd pushed word, wordCount=3.
- Mask: expect 0xFF00...00 with mask 0xFF00...00, DUT sends 0xFF12...34 -> no error. Same word with mask all-ones -> error.
- Fill DEPTH=16 entries -> exp_canReceive=0 after the 16th push. A 17th push is held until the same cycle a DUT pop occurs, then accepted on the next cycle. Wrap-around over 40 words produces no errors.
- strict=1, FIFO empty, dut_isReady high for 3 cycles -> dut_canReceive=0 throughout, errCount=3, firstErr_exp=0. With strict=0 -> errCount=0.
- STOP_ON_FAIL=1, mismatch on word 0 -> halted=1 on the next cycle, dut_canReceive=0 with 5 words queued. clr -> all state returns to reset values. An rst_n pulse mid-stream gives the same result.

Source files
------------

// File: rtl/stream_checker.sv
// stream_checker: queues expected words and compares masked DUT output words, recording failures
module stream_checker #(
  parameter int W = 64,
  parameter int DEPTH = 16,
  parameter int CNT_W = 16,
  parameter bit STOP_ON_FAIL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [W-1:0]     exp,
  input  logic             exp_isReady,
  output logic             exp_canReceive,
  input  logic [W-1:0]     mask,
  input  logic [W-1:0]     dut,
  input  logic             dut_isReady,
  output logic             dut_canReceive,
  input  logic             strict,
  output logic             fail,
  output logic             halted,
  output logic [CNT_W-1:0] wordCount,
  output logic [CNT_W-1:0] errCount,
  output logic [CNT_W-1:0] firstErr_idx,
  output logic [W-1:0]     firstErr_got,
  output logic [W-1:0]     firstErr_exp,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] exp_mem [DEPTH];
  logic [W-1:0] mask_mem [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic fail_q, fail_d, halted_q, halted_d;
  logic [CNT_W-1:0] wc_q, wc_d, ec_q, ec_d, fi_q, fi_d;
  logic [W-1:0] fg_q, fg_d, fe_q, fe_d;
  logic [W-1:0] head_exp, head_mask;
  logic push, pop, mism, unexp, err, first;
  assign head_exp = exp_mem[rd_q];
  assign head_mask = mask_mem[rd_q];
  assign empty = cnt_q == '0;
  // DEPTH is a power of two and count never exceeds it, so the MSB alone marks full
  assign exp_canReceive = !cnt_q[AW];
  assign dut_canReceive = !empty && !halted_q;
  assign fail = fail_q;
  assign halted = halted_q;
  assign wordCount = wc_q;
  assign errCount = ec_q;
  assign firstErr_idx = fi_q;
  assign firstErr_got = fg_q;
  assign firstErr_exp = fe_q;
  // next-state: FIFO bookkeeping, compare, saturating counters and first-failure capture
  always_comb begin
    push = exp_isReady && exp_canReceive;
    pop = dut_isReady && dut_canReceive;
    mism = pop && (((dut ^ head_exp) & head_mask) != '0);
    unexp = strict && dut_isReady && empty && !halted_q;
    err = mism || unexp;
    first = err && !fail_q;
    wr_d = clr ? '0 : wr_q + AW'(push);
    rd_d = clr ? '0 : rd_q + AW'(pop);
    cnt_d = clr ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    wc_d = clr ? '0 : (pop && wc_q != '1) ? wc_q + CNT_W'(1) : wc_q;
    ec_d = clr ? '0 : (err && ec_q != '1) ? ec_q + CNT_W'(1) : ec_q;
    fail_d = !clr && (fail_q || err);
    halted_d = STOP_ON_FAIL && !clr && (halted_q || err);
    fi_d = clr ? '0 : first ? wc_q : fi_q;
    fg_d = clr ? '0 : first ? dut : fg_q;
    fe_d = clr ? '0 : first ? (mism ? head_exp & head_mask : '0) : fe_q;
  end
  // FIFO storage; unreset because pointers and count define validity
  always_ff @(posedge clk) begin
    if (push && !clr) begin
      exp_mem[wr_q] <= exp;
      mask_mem[wr_q] <= mask;
    end
  end
  // state registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      fail_q <= 1'b0;
      halted_q <= 1'b0;
      wc_q <= '0;
      ec_q <= '0;
      fi_q <= '0;
      fg_q <= '0;
      fe_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      fail_q <= fail_d;
      halted_q <= halted_d;
      wc_q <= wc_d;
      ec_q <= ec_d;
      fi_q <= fi_d;
      fg_q <= fg_d;
      fe_q <= fe_d;
    end
  end
endmodule

// File: tb/tb_stream_checker.sv
// tb_stream_checker: scoreboard bench for stream_checker (STOP_ON_FAIL 0 and 1 instances)
module tb_stream_checker;
  localparam logic [63:0] ONES = '1;
  localparam logic [63:0] DEAD = 64'hDEAD_BEEF_DEAD_BEEF;
  logic clk = 0, rst_n = 0, clr = 0, exp_rdy = 0, rdy0 = 0, rdy1 = 0, strict = 0;
  logic [63:0] exp_v = '0, mask_v = '0, dut_v = '0;
  logic o0_ecr, o0_dcr, o0_fail, o0_halt, o0_empty, o1_ecr, o1_dcr, o1_fail, o1_halt, o1_empty;
  logic [15:0] o0_wc, o0_ec, o0_fi, o1_wc, o1_ec, o1_fi;
  logic [63:0] o0_fg, o0_fe, o1_fg, o1_fe;
  int checks = 0, errors = 0;
  bit sb[$];

  stream_checker u0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .exp(exp_v), .exp_isReady(exp_rdy), .exp_canReceive(o0_ecr),
    .mask(mask_v), .dut(dut_v), .dut_isReady(rdy0), .dut_canReceive(o0_dcr), .strict(strict),
    .fail(o0_fail), .halted(o0_halt), .wordCount(o0_wc), .errCount(o0_ec), .firstErr_idx(o0_fi),
    .firstErr_got(o0_fg), .firstErr_exp(o0_fe), .empty(o0_empty));

  stream_checker #(.STOP_ON_FAIL(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .exp(exp_v), .exp_isReady(exp_rdy), .exp_canReceive(o1_ecr),
    .mask(mask_v), .dut(dut_v), .dut_isReady(rdy1), .dut_canReceive(o1_dcr), .strict(strict),
    .fail(o1_fail), .halted(o1_halt), .wordCount(o1_wc), .errCount(o1_ec), .firstErr_idx(o1_fi),
    .firstErr_got(o1_fg), .firstErr_exp(o1_fe), .empty(o1_empty));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr;
    clr = 1;
    tick;
    clr = 0;
  endtask

  task automatic push_word(input logic [63:0] e, input logic [63:0] m, input bit track, input bit mis);
    exp_v = e;
    mask_v = m;
    exp_rdy = 1;
    tick;
    exp_rdy = 0;
    if (track) sb.push_back(mis);
  endtask

  task automatic chk_clean1(input string tag);
    check({tag, "_halted"}, 64'(o1_halt), 0);
    check({tag, "_fail"}, 64'(o1_fail), 0);
    check({tag, "_wc"}, 64'(o1_wc), 0);
    check({tag, "_ec"}, 64'(o1_ec), 0);
    check({tag, "_empty"}, 64'(o1_empty), 1);
    check({tag, "_dcr"}, 64'(o1_dcr), 0);
    check({tag, "_ecr"}, 64'(o1_ecr), 1);
    check({tag, "_fi"}, 64'(o1_fi), 0);
    check({tag, "_fg"}, o1_fg, 0);
    check({tag, "_fe"}, o1_fe, 0);
  endtask

  // monitor: on every u0 consumption pop the predicted mismatch bit and compare counter deltas
  initial begin : mon
    bit cons, mis;
    logic [15:0] ec_b, wc_b;
    forever begin
      @(negedge clk);
      cons = rst_n && !clr && rdy0 && o0_dcr;
      ec_b = o0_ec;
      wc_b = o0_wc;
      @(posedge clk);
      #2;
      if (cons) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mon_unexpected_consume got=consume want=none");
        end else begin
          mis = sb.pop_front();
          check("mon_err_delta", 64'(o0_ec - ec_b), 64'(mis));
          check("mon_word_delta", 64'(o0_wc - wc_b), 1);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pushed_n, cons_n;
    logic [63:0] next_p, next_c;
    bit acc_p, acc_c;
    tick;
    check("rst_ecr", 64'(o0_ecr), 1);
    check("rst_dcr", 64'(o0_dcr), 0);
    check("rst_empty", 64'(o0_empty), 1);
    check("rst_wc", 64'(o0_wc), 0);
    check("rst_fail", 64'(o0_fail), 0);
    tick;
    rst_n = 1;
    tick;
    for (int i = 1; i <= 4; i++) push_word(64'(i), ONES, 1, 0);
    rdy0 = 1;
    for (int i = 1; i <= 4; i++) begin
      dut_v = 64'(i);
      check("t1_dcr", 64'(o0_dcr), 1);
      tick;
    end
    rdy0 = 0;
    check("t1_wc", 64'(o0_wc), 4);
    check("t1_ec", 64'(o0_ec), 0);
    check("t1_fail", 64'(o0_fail), 0);
    check("t1_empty", 64'(o0_empty), 1);
    do_clr;
    push_word(64'hA5A5_0000_0000_0001, ONES, 1, 0);
    push_word(64'h0123_4567_89AB_CDEF, ONES, 1, 1);
    push_word(64'hA5A5_0000_0000_0003, ONES, 1, 0);
    rdy0 = 1;
    dut_v = 64'hA5A5_0000_0000_0001;
    tick;
    dut_v = DEAD;
    tick;
    dut_v = 64'hA5A5_0000_0000_0003;
    tick;
    rdy0 = 0;
    check("t2_fail", 64'(o0_fail), 1);
    check("t2_ec", 64'(o0_ec), 1);
    check("t2_fi", 64'(o0_fi), 1);
    check("t2_fg", o0_fg, DEAD);
    check("t2_fe", o0_fe, 64'h0123_4567_89AB_CDEF);
    check("t2_wc", 64'(o0_wc), 3);
    do_clr;
    push_word(64'hFF00_0000_0000_0000, 64'hFF00_0000_0000_0000, 1, 0);
    push_word(64'hFF00_0000_0000_0000, ONES, 1, 1);
    rdy0 = 1;
    dut_v = 64'hFF12_0000_0000_0034;
    tick;
    check("t3_masked_ok", 64'(o0_ec), 0);
    tick;
    rdy0 = 0;
    check("t3_ec", 64'(o0_ec), 1);
    check("t3_fi", 64'(o0_fi), 1);
    check("t3_fe", o0_fe, 64'hFF00_0000_0000_0000);
    do_clr;
    for (int i = 0; i < 16; i++) push_word(64'(100 + i), ONES, 1, 0);
    check("t4_full", 64'(o0_ecr), 0);
    exp_v = 64'd116;
    exp_rdy = 1;
    tick;
    check("t4_held", 64'(o0_ecr), 0);
    dut_v = 64'd100;
    rdy0 = 1;
    check("t4_dcr_full", 64'(o0_dcr), 1);
    tick;
    rdy0 = 0;
    check("t4_freed", 64'(o0_ecr), 1);
    tick;
    sb.push_back(0);
    check("t4_refull", 64'(o0_ecr), 0);
    pushed_n = 17;
    cons_n = 1;
    next_p = 64'd117;
    next_c = 64'd101;
    for (int cyc = 0; cyc < 200 && cons_n < 40; cyc++) begin
      exp_rdy = pushed_n < 40;
      exp_v = next_p;
      mask_v = ONES;
      rdy0 = 1;
      dut_v = next_c;
      acc_p = exp_rdy && o0_ecr;
      acc_c = rdy0 && o0_dcr;
      tick;
      if (acc_p) begin
        sb.push_back(0);
        pushed_n++;
        next_p++;
      end
      if (acc_c) begin
        cons_n++;
        next_c++;
      end
    end
    exp_rdy = 0;
    rdy0 = 0;
    check("t4_stream_done", 64'(cons_n), 40);
    check("t4_ec", 64'(o0_ec), 0);
    check("t4_wc", 64'(o0_wc), 40);
    check("t4_empty", 64'(o0_empty), 1);
    do_clr;
    strict = 1;
    rdy0 = 1;
    dut_v = DEAD;
    for (int i = 0; i < 3; i++) begin
      check("t5_dcr", 64'(o0_dcr), 0);
      tick;
    end
    rdy0 = 0;
    strict = 0;
    check("t5_ec", 64'(o0_ec), 3);
    check("t5_fail", 64'(o0_fail), 1);
    check("t5_fe", o0_fe, 0);
    check("t5_fg", o0_fg, DEAD);
    check("t5_fi", 64'(o0_fi), 0);
    check("t5_wc", 64'(o0_wc), 0);
    check("t5_nohalt", 64'(o0_halt), 0);
    do_clr;
    rdy0 = 1;
    for (int i = 0; i < 3; i++) tick;
    rdy0 = 0;
    check("t5_lax_ec", 64'(o0_ec), 0);
    check("t5_lax_fail", 64'(o0_fail), 0);
    do_clr;
    for (int i = 0; i < 6; i++) push_word(64'(200 + i), ONES, 0, 0);
    rdy1 = 1;
    dut_v = 64'hBAD;
    check("t6_dcr_pre", 64'(o1_dcr), 1);
    tick;
    check("t6_halted", 64'(o1_halt), 1);
    check("t6_dcr", 64'(o1_dcr), 0);
    check("t6_ec", 64'(o1_ec), 1);
    check("t6_wc", 64'(o1_wc), 1);
    check("t6_fe", o1_fe, 64'd200);
    check("t6_fg", o1_fg, 64'hBAD);
    dut_v = 64'd201;
    tick;
    tick;
    check("t6_wc_hold", 64'(o1_wc), 1);
    check("t6_ecr", 64'(o1_ecr), 1);
    push_word(64'd206, ONES, 0, 0);
    check("t6_still_halted", 64'(o1_halt), 1);
    check("t6_not_empty", 64'(o1_empty), 0);
    do_clr;
    chk_clean1("t6_clr");
    for (int i = 0; i < 3; i++) push_word(64'(300 + i), ONES, 0, 0);
    dut_v = 64'hBAD;
    tick;
    check("t6_halted2", 64'(o1_halt), 1);
    rst_n = 0;
    #2;
    rst_n = 1;
    rdy1 = 0;
    chk_clean1("t6_rst");
    tick;
    tick;
    check("sb_drained", 64'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
